// File: rtl/scan_mux.sv
// scan_mux: registered N-channel, W-bit multiplexer with manual select and
// auto-scan modes. Reports the channel driving the output and pulses
// chan_strobe for one cycle whenever the scan advances to a new channel.
module scan_mux #(
  parameter  int unsigned WIDTH    = 4,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DWELL    = 4,
  localparam int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SELW-1:0]           out_sel,
  output logic                      chan_strobe
);

  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SELW-1:0]  cur_ch_q, cur_ch_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             strobe_q, strobe_d;
  logic             sel_ok;
  logic [SELW-1:0]  next_ch;

  // Out-of-range manual indices are only possible when CHANNELS is not a power of two.
  if (CHANNELS == (2 ** SELW)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (sel < SELW'(CHANNELS));
  end

  // Scan successor of the current channel, wrapping after the last one.
  always_comb begin
    next_ch = (cur_ch_q == SELW'(CHANNELS - 1)) ? '0 : cur_ch_q + SELW'(1);
  end

  // Next-state logic: hold freezes everything, otherwise mode decides the transition.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    dwell_d  = dwell_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    if (!hold) begin
      unique case (state_q)
        MANUAL: begin
          dwell_d = '0;
          if (mode) begin
            state_d = SCAN;
          end else if (sel_ok) begin
            cur_ch_d = sel;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_d = MANUAL;
            dwell_d = '0;
            if (sel_ok) begin
              cur_ch_d = sel;
            end
          end else if (dwell_q == DW'(DWELL - 1)) begin
            dwell_d  = '0;
            cur_ch_d = next_ch;
            strobe_d = 1'b1;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        default: state_d = MANUAL;
      endcase
      // Output data always follows the channel being loaded on this edge.
      out_d = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (cur_ch_d == SELW'(k)) begin
          out_d = data_in[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MANUAL;
      cur_ch_q <= '0;
      dwell_q  <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      dwell_q  <= dwell_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

  assign out         = out_q;
  assign out_sel     = cur_ch_q;
  assign chan_strobe = strobe_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: two instances (4 channels / dwell 3, and 3 channels /
// dwell 1). Expected outputs come from hand-written vector tables or from a
// small behavioural model, queued when stimulus is driven and compared after
// the following clock edge.
module tb_scan_mux;

  logic        clock;
  logic        resetn;

  logic [15:0] a_data;
  logic [1:0]  a_sel;
  logic        a_mode, a_hold;
  logic [3:0]  a_out;
  logic [1:0]  a_osel;
  logic        a_strb;

  logic [11:0] b_data;
  logic [1:0]  b_sel;
  logic        b_mode, b_hold;
  logic [3:0]  b_out;
  logic [1:0]  b_osel;
  logic        b_strb;

  scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut_a (
    .clock(clock), .resetn(resetn), .data_in(a_data), .sel(a_sel),
    .mode(a_mode), .hold(a_hold), .out(a_out), .out_sel(a_osel),
    .chan_strobe(a_strb)
  );

  scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut_b (
    .clock(clock), .resetn(resetn), .data_in(b_data), .sel(b_sel),
    .mode(b_mode), .hold(b_hold), .out(b_out), .out_sel(b_osel),
    .chan_strobe(b_strb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         dut;
    logic [1:0] sel;
    logic       mode;
    logic       hold;
    logic [3:0] e_out;
    logic [1:0] e_sel;
    logic       e_strb;
  } vec_t;

  typedef struct {
    bit         scan;
    int         cur;
    int         dw;
    logic [3:0] out;
    int         osel;
    bit         strb;
  } mst_t;

  typedef struct {
    int         dut;
    string      name;
    logic [3:0] out;
    logic [1:0] osel;
    logic       strb;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  mst_t ma, mb;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic mst_t mreset();
    mst_t s;
    s.scan = 0; s.cur = 0; s.dw = 0; s.out = '0; s.osel = 0; s.strb = 0;
    return s;
  endfunction

  // Behavioural reference for one clock edge.
  function automatic mst_t mstep(mst_t s, int ch, int dwell, logic [15:0] data,
                                 int sel, bit mode, bit hold);
    mst_t n = s;
    n.strb = 0;
    if (hold) return n;
    if (!s.scan) begin
      n.dw = 0;
      if (mode) n.scan = 1;
      else if (sel < ch) n.cur = sel;
    end else if (!mode) begin
      n.scan = 0;
      n.dw = 0;
      if (sel < ch) n.cur = sel;
    end else if (s.dw == dwell - 1) begin
      n.dw = 0;
      n.cur = (s.cur + 1) % ch;
      n.strb = 1;
    end else begin
      n.dw = s.dw + 1;
    end
    n.out  = data[n.cur*4 +: 4];
    n.osel = n.cur;
    return n;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(string name);
    check({name, " a_out"},  {4'h0, a_out},  8'h00);
    check({name, " a_osel"}, {6'h0, a_osel}, 8'h00);
    check({name, " a_strb"}, {7'h0, a_strb}, 8'h00);
    check({name, " b_out"},  {4'h0, b_out},  8'h00);
    check({name, " b_osel"}, {6'h0, b_osel}, 8'h00);
    check({name, " b_strb"}, {7'h0, b_strb}, 8'h00);
  endtask

  // Queue expectations for the inputs now applied, then clock and compare.
  task automatic cycle(string name, bit use_row, vec_t row);
    exp_t e;
    ma = mstep(ma, 4, 3, a_data, int'(a_sel), a_mode, a_hold);
    mb = mstep(mb, 3, 1, {4'h0, b_data}, int'(b_sel), b_mode, b_hold);
    e.name = name;
    e.dut = 0;
    if (use_row && row.dut == 0) begin
      e.out = row.e_out; e.osel = row.e_sel; e.strb = row.e_strb;
    end else begin
      e.out = ma.out; e.osel = 2'(ma.osel); e.strb = ma.strb;
    end
    sb.push_back(e);
    e.dut = 1;
    if (use_row && row.dut == 1) begin
      e.out = row.e_out; e.osel = row.e_sel; e.strb = row.e_strb;
    end else begin
      e.out = mb.out; e.osel = 2'(mb.osel); e.strb = mb.strb;
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        check({e.name, " a_out"},  {4'h0, a_out},  {4'h0, e.out});
        check({e.name, " a_osel"}, {6'h0, a_osel}, {6'h0, e.osel});
        check({e.name, " a_strb"}, {7'h0, a_strb}, {7'h0, e.strb});
      end else begin
        check({e.name, " b_out"},  {4'h0, b_out},  {4'h0, e.out});
        check({e.name, " b_osel"}, {6'h0, b_osel}, {6'h0, e.osel});
        check({e.name, " b_strb"}, {7'h0, b_strb}, {7'h0, e.strb});
      end
    end
  endtask

  initial begin
    vec_t none;
    none = '{0, 2'd0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0};

    a_data = 16'hD5A3; a_sel = '0; a_mode = 1'b0; a_hold = 1'b0;
    b_data = 12'h5A3;  b_sel = '0; b_mode = 1'b0; b_hold = 1'b0;
    resetn = 1'b0;

    // {dut, sel, mode, hold, out, out_sel, strobe}
    // dut_a manual select steps, then park on channel 2.
    vecs.push_back('{0, 2'd0, 1'b0, 1'b0, 4'h3, 2'd0, 1'b0});
    vecs.push_back('{0, 2'd1, 1'b0, 1'b0, 4'hA, 2'd1, 1'b0});
    vecs.push_back('{0, 2'd2, 1'b0, 1'b0, 4'h5, 2'd2, 1'b0});
    vecs.push_back('{0, 2'd3, 1'b0, 1'b0, 4'hD, 2'd3, 1'b0});
    vecs.push_back('{0, 2'd2, 1'b0, 1'b0, 4'h5, 2'd2, 1'b0});
    // dut_a scan from channel 2, dwell 3, with wrap; sel is ignored.
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'h5, 2'd2, 1'b0});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'h5, 2'd2, 1'b0});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'h5, 2'd2, 1'b0});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'hD, 2'd3, 1'b1});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'hD, 2'd3, 1'b0});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'hD, 2'd3, 1'b0});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'h3, 2'd0, 1'b1});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'h3, 2'd0, 1'b0});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'h3, 2'd0, 1'b0});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'hA, 2'd1, 1'b1});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'hA, 2'd1, 1'b0});
    vecs.push_back('{0, 2'd0, 1'b1, 1'b0, 4'hA, 2'd1, 1'b0});
    // dut_b (3 channels, dwell 1): advance every edge, wrap 2->0, then manual range rule.
    vecs.push_back('{1, 2'd0, 1'b1, 1'b0, 4'h3, 2'd0, 1'b0});
    vecs.push_back('{1, 2'd0, 1'b1, 1'b0, 4'hA, 2'd1, 1'b1});
    vecs.push_back('{1, 2'd0, 1'b1, 1'b0, 4'h5, 2'd2, 1'b1});
    vecs.push_back('{1, 2'd0, 1'b1, 1'b0, 4'h3, 2'd0, 1'b1});
    vecs.push_back('{1, 2'd1, 1'b0, 1'b0, 4'hA, 2'd1, 1'b0});
    vecs.push_back('{1, 2'd3, 1'b0, 1'b0, 4'hA, 2'd1, 1'b0});
    vecs.push_back('{1, 2'd2, 1'b0, 1'b0, 4'h5, 2'd2, 1'b0});

    // Reset state while resetn is held low.
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset_hold");
    resetn = 1'b1;
    ma = mreset();
    mb = mreset();

    foreach (vecs[i]) begin
      if (vecs[i].dut == 0) begin
        a_sel = vecs[i].sel; a_mode = vecs[i].mode; a_hold = vecs[i].hold;
      end else begin
        b_sel = vecs[i].sel; b_mode = vecs[i].mode; b_hold = vecs[i].hold;
      end
      cycle($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end

    // Hold mid-dwell: frozen outputs despite data change, then resume remaining dwell.
    for (int i = 0; i < 10 && ma.dw != 1; i++) cycle("pre_hold", 1'b0, none);
    a_hold = 1'b1;
    cycle("hold0", 1'b0, none);
    a_data = 16'h1B7C;
    repeat (4) cycle("hold", 1'b0, none);
    a_hold = 1'b0;
    repeat (8) cycle("post_hold", 1'b0, none);

    // Hold right after a strobe edge forces the strobe low.
    for (int i = 0; i < 12 && !ma.strb; i++) cycle("seek_strobe", 1'b0, none);
    a_hold = 1'b1;
    b_hold = 1'b1; b_sel = 2'd0;
    repeat (2) cycle("hold_strobe", 1'b0, none);
    a_hold = 1'b0;
    b_hold = 1'b0;
    repeat (4) cycle("after_hold_strobe", 1'b0, none);

    // Scan back to manual on dut_a loads sel on the same edge.
    a_mode = 1'b0; a_sel = 2'd1;
    cycle("a_to_manual", 1'b0, none);
    a_data = 16'h9E42;
    cycle("a_data_change", 1'b0, none);

    // Reset pulse mid-scan at channel 2, dwell count 2, mode left at 1.
    a_sel = 2'd2;
    cycle("a_sel2", 1'b0, none);
    a_mode = 1'b1;
    repeat (3) cycle("a_scan_to_dw2", 1'b0, none);
    #1 resetn = 1'b0;
    #2;
    check_reset_outputs("reset_async");
    ma = mreset();
    mb = mreset();
    #2 resetn = 1'b1;
    repeat (8) cycle("after_reset", 1'b0, none);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
